srio_ireq_hello_packer: RTL and testbench

//  Downstream stage of the NWRITE data generator. Takes the user request stream and builds

---
 rtl/srio_ireq_hello_packer.sv | 116 +++++++++++
 tb/tb_srio_ireq_hello_packer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/srio_ireq_hello_packer.sv
// rtl/srio_ireq_hello_packer.sv - builds SRIO HELLO header + pass-through data packets on ireq
module srio_ireq_hello_packer #(
  parameter logic [15:0] SRC_ID  = 16'h0001,
  parameter logic [15:0] DEST_ID = 16'h00F0,
  parameter logic [1:0]  PRIO    = 2'b01,
  parameter logic        CRF     = 1'b0
) (
  input  logic        log_clk,
  input  logic        log_rst_n,
  input  logic [33:0] user_addr_in,
  input  logic [3:0]  user_ftype_in,
  input  logic [3:0]  user_ttype_in,
  input  logic [11:0] user_tsize_in,
  input  logic [63:0] user_tdata_in,
  input  logic        user_tvalid_in,
  input  logic [7:0]  user_tkeep_in,
  input  logic        user_tlast_in,
  output logic        user_tready_o,
  output logic        nwr_ready_o,
  output logic        nwr_busy_o,
  output logic [63:0] ireq_tdata_o,
  output logic        ireq_tvalid_o,
  output logic [7:0]  ireq_tkeep_o,
  output logic        ireq_tlast_o,
  output logic [31:0] ireq_tuser_o,
  input  logic        ireq_tready_in,
  output logic [15:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DROP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  tid;
  logic [33:0] addr_q;
  logic [3:0]  ftype_q;
  logic [3:0]  ttype_q;
  logic [7:0]  tsize_q;
  logic        data_done;
  logic        drop_done;

  assign data_done = (state == DATA) && user_tvalid_in && ireq_tready_in && user_tlast_in;
  assign drop_done = (state == DROP) && user_tvalid_in && user_tlast_in;

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      state     <= IDLE;
      tid       <= 8'd0;
      addr_q    <= 34'd0;
      ftype_q   <= 4'd0;
      ttype_q   <= 4'd0;
      tsize_q   <= 8'd0;
      pkt_cnt_o <= 16'd0;
      err_cnt_o <= 16'd0;
    end else begin
      state <= state_nxt;
      // Request fields are captured while the first beat is still held upstream.
      if (state == IDLE && user_tvalid_in) begin
        addr_q  <= user_addr_in;
        ftype_q <= user_ftype_in;
        ttype_q <= user_ttype_in;
        tsize_q <= user_tsize_in[7:0];
      end
      if (state == HDR && ireq_tready_in)
        tid <= tid + 8'd1;
      if (data_done)
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      if (drop_done && err_cnt_o != 16'hFFFF)
        err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    user_tready_o = 1'b0;
    nwr_ready_o   = 1'b0;
    nwr_busy_o    = 1'b1;
    ireq_tdata_o  = 64'd0;
    ireq_tvalid_o = 1'b0;
    ireq_tkeep_o  = 8'd0;
    ireq_tlast_o  = 1'b0;
    case (state)
      IDLE: begin
        nwr_ready_o = 1'b1;
        nwr_busy_o  = 1'b0;
        if (user_tvalid_in)
          state_nxt = (user_tsize_in > 12'd255) ? DROP : HDR;
      end
      HDR: begin
        ireq_tvalid_o = 1'b1;
        ireq_tkeep_o  = 8'hFF;
        ireq_tdata_o  = {tid, ftype_q, ttype_q, 1'b0, PRIO, CRF, tsize_q, 2'b00, addr_q};
        if (ireq_tready_in)
          state_nxt = DATA;
      end
      DATA: begin
        ireq_tvalid_o = user_tvalid_in;
        ireq_tdata_o  = user_tdata_in;
        ireq_tkeep_o  = user_tkeep_in;
        ireq_tlast_o  = user_tlast_in;
        user_tready_o = ireq_tready_in;
        if (data_done)
          state_nxt = IDLE;
      end
      DROP: begin
        user_tready_o = 1'b1;
        if (drop_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ireq_tuser_o = {SRC_ID, DEST_ID};

endmodule

// File: tb/tb_srio_ireq_hello_packer.sv
// tb/tb_srio_ireq_hello_packer.sv - scoreboard bench for the HELLO ireq packer
module tb_srio_ireq_hello_packer;

  logic        log_clk = 1'b0;
  logic        log_rst_n = 1'b0;
  logic [33:0] user_addr_in = '0;
  logic [3:0]  user_ftype_in = '0;
  logic [3:0]  user_ttype_in = '0;
  logic [11:0] user_tsize_in = '0;
  logic [63:0] user_tdata_in = '0;
  logic        user_tvalid_in = 1'b0;
  logic [7:0]  user_tkeep_in = '0;
  logic        user_tlast_in = 1'b0;
  logic        user_tready_o;
  logic        nwr_ready_o;
  logic        nwr_busy_o;
  logic [63:0] ireq_tdata_o;
  logic        ireq_tvalid_o;
  logic [7:0]  ireq_tkeep_o;
  logic        ireq_tlast_o;
  logic [31:0] ireq_tuser_o;
  logic        ireq_tready_in = 1'b0;
  logic [15:0] pkt_cnt_o;
  logic [15:0] err_cnt_o;

  srio_ireq_hello_packer dut (
    .log_clk(log_clk), .log_rst_n(log_rst_n),
    .user_addr_in(user_addr_in), .user_ftype_in(user_ftype_in),
    .user_ttype_in(user_ttype_in), .user_tsize_in(user_tsize_in),
    .user_tdata_in(user_tdata_in), .user_tvalid_in(user_tvalid_in),
    .user_tkeep_in(user_tkeep_in), .user_tlast_in(user_tlast_in),
    .user_tready_o(user_tready_o), .nwr_ready_o(nwr_ready_o), .nwr_busy_o(nwr_busy_o),
    .ireq_tdata_o(ireq_tdata_o), .ireq_tvalid_o(ireq_tvalid_o),
    .ireq_tkeep_o(ireq_tkeep_o), .ireq_tlast_o(ireq_tlast_o),
    .ireq_tuser_o(ireq_tuser_o), .ireq_tready_in(ireq_tready_in),
    .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 log_clk = ~log_clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [72:0] sb_q[$];
  logic [7:0]  exp_tid = 8'd0;
  int          exp_pkt = 0;
  int          exp_err = 0;

  function automatic logic [63:0] hello_hdr(input logic [7:0] t, input logic [3:0] f,
                                            input logic [3:0] tt, input logic [11:0] ts,
                                            input logic [33:0] a);
    return {t, f, tt, 1'b0, 2'b01, 1'b0, ts[7:0], 2'b00, a};
  endfunction

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every accepted ireq beat is matched against the head of the scoreboard.
  always @(negedge log_clk) begin
    if (log_rst_n && ireq_tvalid_o && ireq_tready_in) begin
      if (sb_q.size() == 0)
        check("ireq_unexpected_beat", {ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o}, 73'd0 - 73'd1);
      else
        check("ireq_beat", {ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o}, sb_q.pop_front());
    end
  end

  task automatic send_pkt(input logic [33:0] a, input logic [3:0] f, input logic [3:0] tt,
                          input logic [11:0] ts, input logic [7:0] tail_keep,
                          input bit rnd, input int abort_beat);
    int   nbeats;
    bit   drop;
    bit   hs;
    int   guard;
    logic [63:0] d;
    logic [7:0]  k;
    nbeats = (int'(ts) + 8) / 8;
    drop   = (ts > 12'd255);
    if (!drop) begin
      sb_q.push_back({hello_hdr(exp_tid, f, tt, ts, a), 8'hFF, 1'b0});
      exp_tid++;
    end
    user_addr_in = a; user_ftype_in = f; user_ttype_in = tt; user_tsize_in = ts;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_beat) begin
        log_rst_n = 1'b0;
        #1;
        check("abort_outputs", {55'd0, ireq_tvalid_o, user_tready_o, nwr_ready_o, nwr_busy_o,
              ireq_tlast_o, ireq_tkeep_o, ireq_tdata_o == 64'd0},
              {55'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1});
        check("abort_counters", {41'd0, pkt_cnt_o, err_cnt_o}, 73'd0);
        sb_q.delete();
        exp_tid = 8'd0; exp_pkt = 0; exp_err = 0;
        user_tvalid_in = 1'b0; user_tlast_in = 1'b0;
        @(posedge log_clk); #1;
        log_rst_n = 1'b1;
        return;
      end
      d = {$urandom, $urandom};
      k = (i == nbeats - 1) ? tail_keep : 8'hFF;
      user_tdata_in = d; user_tkeep_in = k; user_tlast_in = (i == nbeats - 1);
      user_tvalid_in = 1'b1;
      if (!drop) sb_q.push_back({d, k, i == nbeats - 1});
      guard = 0;
      do begin
        ireq_tready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge log_clk);
        hs = user_tready_o;
        @(posedge log_clk); #1;
        guard++;
      end while (!hs && guard < 1000);
      if (!hs) check("beat_timeout", 73'd0, 73'd1);
    end
    user_tvalid_in = 1'b0; user_tlast_in = 1'b0;
    if (drop) exp_err++; else exp_pkt++;
    guard = 0;
    while (!nwr_ready_o && guard < 100) begin
      @(posedge log_clk); #1; guard++;
    end
    check("return_idle", {72'd0, nwr_ready_o}, 73'd1);
  endtask

  initial begin
    // T1 reset state
    #1;
    check("rst_outputs", {ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o}, 73'd0);
    check("rst_status", {68'd0, ireq_tvalid_o, user_tready_o, nwr_ready_o, nwr_busy_o, 1'b0},
          {68'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("rst_tuser", {41'd0, ireq_tuser_o}, {41'd0, 32'h0001_00F0});
    check("rst_counters", {41'd0, pkt_cnt_o, err_cnt_o}, 73'd0);
    @(posedge log_clk); #1;
    log_rst_n = 1'b1;
    @(posedge log_clk); #1;

    // T2 max legal packet, always ready
    send_pkt(34'h1_0000_0000, 4'd5, 4'd4, 12'd255, 8'hFF, 1'b0, -1);
    check("t2_pkt_cnt", {57'd0, pkt_cnt_o}, {57'd0, 16'(exp_pkt)});

    // T3 partial tail with a randomly stalling core
    send_pkt(34'h2_1234_5678, 4'd5, 4'd4, 12'd250, 8'hF8, 1'b1, -1);
    check("t3_pkt_cnt", {57'd0, pkt_cnt_o}, {57'd0, 16'(exp_pkt)});

    // T4 tid wrap across 257 single-beat packets
    for (int p = 0; p < 257; p++)
      send_pkt(34'(p * 8), 4'd5, 4'd4, 12'd7, 8'hFF, 1'b0, -1);
    check("t4_pkt_cnt", {57'd0, pkt_cnt_o}, {57'd0, 16'(exp_pkt)});

    // T5 oversize request is drained and counted
    send_pkt(34'h0_0000_1000, 4'd5, 4'd4, 12'h1FF, 8'hFF, 1'b0, -1);
    check("t5_err_cnt", {57'd0, err_cnt_o}, {57'd0, 16'(exp_err)});
    check("t5_pkt_cnt", {57'd0, pkt_cnt_o}, {57'd0, 16'(exp_pkt)});

    // T6 reset mid-packet, then a clean packet restarting at tid 0
    send_pkt(34'h0_0000_2000, 4'd5, 4'd4, 12'd255, 8'hFF, 1'b0, 10);
    @(posedge log_clk); #1;
    send_pkt(34'h3_0000_0040, 4'd5, 4'd4, 12'd63, 8'hFF, 1'b0, -1);
    check("t6_pkt_cnt", {57'd0, pkt_cnt_o}, {57'd0, 16'(exp_pkt)});

    repeat (4) @(posedge log_clk);
    #1;
    check("sb_drained", {41'd0, 32'(sb_q.size())}, 73'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
